instruction_fetch_queue: RTL and testbench
==========================================

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning byte address fetched first after reset.
REQ-003 SHALL have parameter MEM_BYTES, default 32, meaning instruction memory size in bytes (multiple of 4).
REQ-004 SHALL have port clk, input, 1, meaning rising-edge clock.
REQ-005 SHALL have port reset, input, 1, meaning reset: synchronous, active-high.
REQ-006 SHALL have port imem_addr, output, 32, meaning byte address to instruction memory (fetch_pc).
REQ-007 SHALL have port imem_instr, input, 32, meaning combinational little-endian word read at imem_addr.
REQ-008 SHALL have port redirect_valid, input, 1, meaning flush and restart fetch.
REQ-009 SHALL have port redirect_pc, input, 32, meaning new fetch byte address.
REQ-010 SHALL have port out_valid, output, 1, meaning FIFO head valid to decode.
REQ-011 SHALL have port out_ready, input, 1, meaning decode accepts head.
REQ-012 SHALL have port out_instr, output, 32, meaning head instruction.
REQ-013 SHALL have port out_pc, output, 32, meaning head instruction address.
REQ-014 SHALL have port halted, output, 1, meaning state is HALT.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1, meaning FIFO occupancy.

Function
REQ-016 SHALL implement states BOOT, FETCH, HALT; BOOT lasts exactly one cycle after reset deasserts (memory settles), then FETCH.
REQ-017 SHALL drive imem_addr = fetch_pc combinationally in all states.
REQ-018 In FETCH, push {fetch_pc, imem_instr} when count<DEPTH or a pop occurs in the same cycle; on push, fetch_pc <= fetch_pc+4, wrapping to 0 when fetch_pc+4 >= MEM_BYTES.
REQ-019 SHALL not push in BOOT or HALT; fetch_pc holds.
REQ-020 In FETCH, a pushed word equal to 32'h0000_0000 SHALL still be enqueued, then state -> HALT, fetch_pc holds at that word's address +4 (wrapped).
REQ-021 Pop occurs when out_valid && out_ready; out_instr/out_pc SHALL present the oldest entry, registered storage, no combinational path from imem_instr.
REQ-022 out_valid SHALL equal (count != 0); first instruction visible one cycle after its push (push-to-output latency 1).
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-024 redirect_valid SHALL have priority over push and pop: FIFO emptied (count 0), fetch_pc <= {redirect_pc[31:2],2'b00} wrapped modulo MEM_BYTES, state -> FETCH from FETCH or HALT; no push or pop that cycle.
REQ-025 redirect_valid in BOOT SHALL load fetch_pc, state remains per REQ-016.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-027 out_ready asserted while empty SHALL have no effect.

Reset
REQ-028 On reset high at a rising edge: state BOOT, fetch_pc RESET_PC, count 0, out_valid 0, out_instr 0, out_pc 0, halted 0, pointers 0; reset dominates redirect_valid.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents in that cycle.

Verification
REQ-030 Reset, memory words 0x00500093,0x00100113,0x002081B3,0 at 0,4,8,12, out_ready=1 -> BOOT one cycle, then out_pc 0,4,8,12 on consecutive cycles with matching out_instr, halted=1 after push of addr 12.
REQ-031 out_ready=0, nonzero memory -> count rises 1..4, holds at 4, imem_addr stalls at 16; then out_ready=1 -> one pop and one push per cycle, count stays 4.
REQ-032 Redirect_pc=0x0000_0013 while count=3 -> next cycle count 0, out_valid 0, imem_addr 0x10; following cycle out_pc 0x10.
REQ-033 Sequential fetch from 0x1C with MEM_BYTES=32 -> next out_pc 0x00 (wrap).
REQ-034 In HALT, redirect_pc 0x08 -> halted 0 next cycle, fetch resumes at 0x08.
REQ-035 Reset asserted with count=2 and redirect_valid=1 -> count 0, fetch_pc RESET_PC, state BOOT.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - sequential instruction fetcher feeding a decode FIFO
//
// Fetches 32-bit words from a combinational instruction memory at fetch_pc and
// queues {pc, instr} pairs for decode. A fetched all-zero word is queued and then
// stops fetching (HALT) until a redirect.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   imem_addr/instr     fetch address out, combinational memory word in
//   redirect_valid/pc   flush queue and restart fetch at redirect_pc (word aligned)
//   out_valid/ready     decode handshake for the queue head
//   out_instr/out_pc    head entry, driven from queue storage only
//   halted              fetcher is in HALT
//   count               queue occupancy
module instruction_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_instr,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    pc_mem_q [DEPTH];
  logic [31:0]    pc_mem_d [DEPTH];
  logic [31:0]    instr_mem_q [DEPTH];
  logic [31:0]    instr_mem_d [DEPTH];

  logic           push;
  logic           pop;
  logic           full;
  logic [31:0]    seq_pc;
  logic [31:0]    redir_pc;

  assign full = (count_q == CW'(DEPTH));

  // Sequential successor of fetch_pc, wrapping at the end of instruction memory.
  always_comb begin
    seq_pc = fetch_pc_q + 32'd4;
    if (seq_pc >= 32'(MEM_BYTES)) begin
      seq_pc = 32'd0;
    end
  end

  assign redir_pc = (redirect_pc & ~32'd3) % 32'(MEM_BYTES);

  // Redirect suppresses both sides of the queue for its cycle.
  assign pop  = (count_q != '0) && out_ready && !redirect_valid;
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign push = (state_q == S_FETCH) && !redirect_valid && (!full || pop);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (redirect_valid) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redir_pc;
      // BOOT still ends after its single cycle, so every state lands in FETCH.
      state_d    = S_FETCH;
    end else begin
      case (state_q)
        S_BOOT:  state_d = S_FETCH;
        S_FETCH: begin
          if (push && (imem_instr == 32'd0)) begin
            state_d = S_HALT;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_BOOT;
      endcase

      if (push) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = imem_instr;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        fetch_pc_d            = seq_pc;
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end

      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= 32'd0;
        instr_mem_q[i] <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  // Stale entries stay in storage after a flush, so the head is masked when empty.
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : 32'd0;
  assign halted    = (state_q == S_HALT);
  assign count     = count_q;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - directed self-checking bench for instruction_fetch_queue
module tb_instruction_fetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic [2:0]  count;

  logic [31:0] mem [8];
  int          passed;
  int          failed;
  int          total;

  instruction_fetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000),
    .MEM_BYTES(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .halted(halted),
    .count(count)
  );

  assign imem_instr = mem[3'((imem_addr >> 2) & 32'd7)];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h0000_0000;
    for (int i = 4; i < 8; i++) mem[i] = 32'h1000_0000 + 32'(i);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b1;

    // Reset state
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    reset = 1'b0;

    // BOOT cycle: no push
    tick();
    check("boot_count", 32'(count), 32'd0);
    check("boot_addr", imem_addr, 32'd0);

    // Program stream with out_ready=1
    tick();
    check("p0_pc", out_pc, 32'h00);
    check("p0_instr", out_instr, 32'h0050_0093);
    check("p0_addr", imem_addr, 32'h04);
    tick();
    check("p1_pc", out_pc, 32'h04);
    check("p1_instr", out_instr, 32'h0010_0113);
    tick();
    check("p2_pc", out_pc, 32'h08);
    check("p2_instr", out_instr, 32'h0020_81B3);
    check("p2_halted", 32'(halted), 32'd0);
    tick();
    check("p3_pc", out_pc, 32'h0C);
    check("p3_instr", out_instr, 32'd0);
    check("p3_halted", 32'(halted), 32'd1);
    check("p3_addr", imem_addr, 32'h10);
    tick();
    check("halt_count", 32'(count), 32'd0);
    check("halt_valid", 32'(out_valid), 32'd0);
    check("halt_addr", imem_addr, 32'h10);
    // out_ready while empty does nothing
    tick();
    check("empty_ready_count", 32'(count), 32'd0);

    // Redirect out of HALT to 0x08, memory now all nonzero, decode stalled
    for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + 32'(i);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h08;
    tick();
    redirect_valid = 1'b0;
    check("redir_halted", 32'(halted), 32'd0);
    check("redir_addr", imem_addr, 32'h08);
    check("redir_count", 32'(count), 32'd0);
    tick();
    check("resume_pc", out_pc, 32'h08);
    check("resume_instr", out_instr, 32'h1000_0002);
    check("resume_count", 32'(count), 32'd1);
    tick();
    tick();
    check("c3_count", 32'(count), 32'd3);

    // Misaligned redirect while count=3
    redirect_valid = 1'b1;
    redirect_pc    = 32'h13;
    tick();
    redirect_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_addr", imem_addr, 32'h10);
    tick();
    check("fill1_pc", out_pc, 32'h10);
    check("fill1_count", 32'(count), 32'd1);
    tick();
    check("fill2_count", 32'(count), 32'd2);
    tick();
    check("fill3_count", 32'(count), 32'd3);
    tick();
    check("fill4_count", 32'(count), 32'd4);
    check("fill4_addr_wrap", imem_addr, 32'h00);
    tick();
    check("full_hold_count", 32'(count), 32'd4);
    check("full_hold_addr", imem_addr, 32'h00);
    check("full_hold_pc", out_pc, 32'h10);

    // Drain while full: one pop and one push each cycle
    out_ready = 1'b1;
    tick();
    check("pp1_count", 32'(count), 32'd4);
    check("pp1_pc", out_pc, 32'h14);
    check("pp1_addr", imem_addr, 32'h04);
    tick();
    check("pp2_pc", out_pc, 32'h18);
    tick();
    check("pp3_pc", out_pc, 32'h1C);
    tick();
    check("wrap_pc", out_pc, 32'h00);
    check("wrap_instr", out_instr, 32'h1000_0000);
    check("wrap_count", 32'(count), 32'd4);

    // Build count=2, then reset together with redirect
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_count", 32'(count), 32'd2);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    check("rst2_count", 32'(count), 32'd0);
    check("rst2_addr", imem_addr, 32'h00);
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_halted", 32'(halted), 32'd0);
    reset          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h08;

    // Redirect during BOOT loads fetch_pc without pushing
    tick();
    redirect_valid = 1'b0;
    check("boot_redir_count", 32'(count), 32'd0);
    check("boot_redir_addr", imem_addr, 32'h08);
    tick();
    check("post_boot_count", 32'(count), 32'd1);
    check("post_boot_pc", out_pc, 32'h08);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
